msrv32_pc_unit: RTL and testbench

Parametrised, registered program-counter unit for the MSRV32 fetch stage. It replaces the combinational next-PC mux with a stateful block that holds the fetch address across AHB wait states and keeps redirects (branch, trap, mret) that arrive during a wait state until the bus can accept them. It also supports 16-bit instruction alignment for the C extension.

---
 rtl/msrv32_pkg.sv | 19 +
 rtl/msrv32_pc_unit_if.sv | 33 +++
 rtl/msrv32_pc_next.sv | 51 +++++
 rtl/msrv32_pc_unit.sv | 137 +++++++++++++
 tb/tb_msrv32_pc_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/msrv32_pkg.sv
// Shared definitions for the MSRV32 program-counter unit.
// Holds the pc_src_in encodings, the PC FSM state codes and default widths.
package msrv32_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

    // pc_src_in encodings
    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    // PC FSM state codes
    localparam logic [1:0] ST_BOOT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

endpackage

// File: rtl/msrv32_pc_unit_if.sv
// Bundle of fetch-side control, address and status signals of the PC unit.
// slave  : seen from the PC unit (control in, addresses/status out).
// master : seen from the driver (core control logic or testbench).
interface msrv32_pc_unit_if #(
    parameter int XLEN = 32
) ();
    logic            ahb_ready_in;
    logic            branch_taken_in;
    logic [1:0]      pc_src_in;
    logic [XLEN-1:0] epc_in;
    logic [XLEN-1:0] trap_address_in;
    logic [XLEN-1:0] iaddr_in;
    logic            instr_16_in;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_step_out;
    logic [XLEN-1:0] i_addr_out;
    logic            misaligned_instr_logic_out;
    logic            redirect_pending_out;

    modport slave (
        input  ahb_ready_in, branch_taken_in, pc_src_in, epc_in,
               trap_address_in, iaddr_in, instr_16_in,
        output pc_out, pc_plus_step_out, i_addr_out,
               misaligned_instr_logic_out, redirect_pending_out
    );

    modport master (
        output ahb_ready_in, branch_taken_in, pc_src_in, epc_in,
               trap_address_in, iaddr_in, instr_16_in,
        input  pc_out, pc_plus_step_out, i_addr_out,
               misaligned_instr_logic_out, redirect_pending_out
    );
endinterface

// File: rtl/msrv32_pc_next.sv
// Combinational next-PC selection for the MSRV32 fetch stage.
// Ports: i_pc (current PC), i_pc_src / i_branch_taken / i_epc / i_trap /
// i_iaddr / i_instr_16 (selection inputs); o_selected (chosen address),
// o_pc_plus_step (sequential successor), o_misaligned (bad branch target),
// o_redirect (this cycle asks for a non-sequential fetch).
module msrv32_pc_next
    import msrv32_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
    parameter int              IALIGN       = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [1:0]      i_pc_src,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_epc,
    input  logic [XLEN-1:0] i_trap,
    input  logic [XLEN-1:0] i_iaddr,
    input  logic            i_instr_16,
    output logic [XLEN-1:0] o_selected,
    output logic [XLEN-1:0] o_pc_plus_step,
    output logic            o_misaligned,
    output logic            o_redirect
);
    localparam logic [XLEN-1:0] STEP_4 = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] STEP_2 = {{(XLEN-3){1'b0}}, 3'd2};

    logic            w_half_step;
    logic [XLEN-1:0] w_tgt;
    logic            w_branch_next;

    // Compressed stepping only exists when 16-bit alignment is enabled.
    assign w_half_step    = (IALIGN == 16) ? i_instr_16 : 1'b0;
    // Wraps modulo 2^XLEN by construction.
    assign o_pc_plus_step = i_pc + (w_half_step ? STEP_2 : STEP_4);
    assign w_tgt          = i_branch_taken ? {i_iaddr[XLEN-1:1], 1'b0} : o_pc_plus_step;
    assign w_branch_next  = i_branch_taken & (i_pc_src == PC_SRC_NEXT);
    assign o_redirect     = (i_pc_src != PC_SRC_NEXT) | w_branch_next;
    assign o_misaligned   = (IALIGN == 32) ? (w_branch_next & w_tgt[1]) : 1'b0;

    // Source mux over the four pc_src encodings.
    always_comb begin
        case (i_pc_src)
            PC_SRC_BOOT: o_selected = BOOT_ADDRESS;
            PC_SRC_EPC:  o_selected = i_epc;
            PC_SRC_TRAP: o_selected = i_trap;
            PC_SRC_NEXT: o_selected = w_tgt;
            default:     o_selected = BOOT_ADDRESS;
        endcase
    end
endmodule

// File: rtl/msrv32_pc_unit.sv
// Registered program-counter unit for the MSRV32 fetch stage.
// Holds the fetch address across AHB wait states and parks redirects
// (branch, trap, mret) raised during a wait state until the bus accepts.
// Ports: ms_riscv32_mp_clk_in (clock), ms_riscv32_mp_rst_in (async,
// active-high reset), bus (msrv32_pc_unit_if slave: control in,
// pc/i_addr/step/status out).
module msrv32_pc_unit
    import msrv32_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT[XLEN-1:0],
    parameter int              IALIGN       = 32
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_in,
    msrv32_pc_unit_if.slave         bus
);
    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_iaddr;
    logic [XLEN-1:0] r_pending;
    logic            r_pending_flag;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_iaddr_nxt;
    logic [XLEN-1:0] w_pending_nxt;
    logic            w_pending_flag_nxt;

    logic [XLEN-1:0] w_selected;
    logic [XLEN-1:0] w_pc_plus_step;
    logic            w_misaligned;
    logic            w_redirect;

    msrv32_pc_next #(
        .XLEN         (XLEN),
        .BOOT_ADDRESS (BOOT_ADDRESS),
        .IALIGN       (IALIGN)
    ) u_pc_next (
        .i_pc           (r_pc),
        .i_pc_src       (bus.pc_src_in),
        .i_branch_taken (bus.branch_taken_in),
        .i_epc          (bus.epc_in),
        .i_trap         (bus.trap_address_in),
        .i_iaddr        (bus.iaddr_in),
        .i_instr_16     (bus.instr_16_in),
        .o_selected     (w_selected),
        .o_pc_plus_step (w_pc_plus_step),
        .o_misaligned   (w_misaligned),
        .o_redirect     (w_redirect)
    );

    // Next-state logic; a misaligned branch freezes everything until the trap arrives.
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_iaddr_nxt        = r_iaddr;
        w_pending_nxt      = r_pending;
        w_pending_flag_nxt = r_pending_flag;
        case (r_state)
            ST_BOOT: begin
                if (bus.ahb_ready_in) begin
                    w_pc_nxt    = BOOT_ADDRESS;
                    w_iaddr_nxt = BOOT_ADDRESS;
                    w_state_nxt = ST_RUN;
                end else if (w_redirect && !w_misaligned) begin
                    w_pending_nxt      = w_selected;
                    w_pending_flag_nxt = 1'b1;
                    w_state_nxt        = ST_HOLD;
                end else begin
                    w_state_nxt = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (w_misaligned) begin
                    w_state_nxt = ST_RUN;
                end else if (bus.ahb_ready_in) begin
                    w_pc_nxt    = w_selected;
                    w_iaddr_nxt = w_selected;
                end else if (w_redirect) begin
                    w_pending_nxt      = w_selected;
                    w_pending_flag_nxt = 1'b1;
                    w_state_nxt        = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (w_misaligned) begin
                    w_state_nxt = ST_HOLD;
                end else if (bus.ahb_ready_in) begin
                    // A redirect arriving together with ready is newer than the parked one.
                    if (w_redirect) begin
                        w_pc_nxt    = w_selected;
                        w_iaddr_nxt = w_selected;
                    end else begin
                        w_pc_nxt    = r_pending;
                        w_iaddr_nxt = r_pending;
                    end
                    w_pending_flag_nxt = 1'b0;
                    w_state_nxt        = ST_RUN;
                end else if (w_redirect) begin
                    w_pending_nxt = w_selected;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt        = ST_BOOT;
                w_pending_flag_nxt = 1'b0;
            end
        endcase
    end

    // State and address registers.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state        <= ST_BOOT;
            r_pc           <= BOOT_ADDRESS;
            r_iaddr        <= BOOT_ADDRESS;
            r_pending      <= '0;
            r_pending_flag <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_iaddr        <= w_iaddr_nxt;
            r_pending      <= w_pending_nxt;
            r_pending_flag <= w_pending_flag_nxt;
        end
    end

    assign bus.pc_out                     = r_pc;
    assign bus.i_addr_out                 = r_iaddr;
    assign bus.pc_plus_step_out           = w_pc_plus_step;
    assign bus.misaligned_instr_logic_out = w_misaligned;
    assign bus.redirect_pending_out       = r_pending_flag;
endmodule

// File: tb/tb_msrv32_pc_unit.sv
// Directed self-checking bench for msrv32_pc_unit: one 32-bit-aligned
// instance (boot 0x0) and one 16-bit-aligned instance (boot 0x1000).
module tb_msrv32_pc_unit;
    logic clk;
    logic rst32;
    logic rst16;
    int   checks;
    int   errors;

    msrv32_pc_unit_if #(.XLEN(32)) if32 ();
    msrv32_pc_unit_if #(.XLEN(32)) if16 ();

    msrv32_pc_unit #(.XLEN(32), .BOOT_ADDRESS(32'h0000_0000), .IALIGN(32)) dut32 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst32),
        .bus                  (if32.slave)
    );

    msrv32_pc_unit #(.XLEN(32), .BOOT_ADDRESS(32'h0000_1000), .IALIGN(16)) dut16 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst16),
        .bus                  (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic rdy, input logic [1:0] src, input logic br,
                           input logic [31:0] ia, input logic [31:0] ep, input logic [31:0] tr);
        if32.ahb_ready_in    = rdy;
        if32.pc_src_in       = src;
        if32.branch_taken_in = br;
        if32.iaddr_in        = ia;
        if32.epc_in          = ep;
        if32.trap_address_in = tr;
    endtask

    task automatic test_reset();
        drive32(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        if32.instr_16_in = 1'b0;
        step();
        checks++;
        if (if32.i_addr_out !== 32'h0 || if32.pc_out !== 32'h0 || if32.redirect_pending_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: i_addr=%h pc=%h flag=%b expected 0/0/0", if32.i_addr_out, if32.pc_out, if32.redirect_pending_out);
        end
        rst32 = 1'b0;
        step();
        checks++;
        if (if32.i_addr_out !== 32'h0) begin
            errors++; $display("FAIL boot_issue: got %h expected 00000000", if32.i_addr_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'h4 || if32.pc_plus_step_out !== 32'h8) begin
            errors++; $display("FAIL seq_4: i_addr=%h step=%h expected 4/8", if32.i_addr_out, if32.pc_plus_step_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'h8) begin
            errors++; $display("FAIL seq_8: got %h expected 8", if32.i_addr_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'hC || if32.pc_out !== 32'hC) begin
            errors++; $display("FAIL seq_12: i_addr=%h pc=%h expected c", if32.i_addr_out, if32.pc_out);
        end
    endtask

    task automatic test_misalign();
        // Bit 0 of the target is dropped: 0x101 lands on 0x100.
        drive32(1'b1, 2'b11, 1'b1, 32'h101, 32'h0, 32'h0);
        step();
        checks++;
        if (if32.i_addr_out !== 32'h100) begin
            errors++; $display("FAIL branch_0x100: got %h expected 100", if32.i_addr_out);
        end
        drive32(1'b1, 2'b11, 1'b1, 32'h202, 32'h0, 32'h0);
        #1;
        checks++;
        if (if32.misaligned_instr_logic_out !== 1'b1) begin
            errors++; $display("FAIL misaligned_flag: got %b expected 1", if32.misaligned_instr_logic_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'h100 || if32.pc_out !== 32'h100) begin
            errors++; $display("FAIL misaligned_hold: i_addr=%h pc=%h expected 100", if32.i_addr_out, if32.pc_out);
        end
        drive32(1'b1, 2'b10, 1'b0, 32'h202, 32'h0, 32'h80);
        #1;
        checks++;
        if (if32.misaligned_instr_logic_out !== 1'b0) begin
            errors++; $display("FAIL trap_not_misaligned: got %b expected 0", if32.misaligned_instr_logic_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'h80) begin
            errors++; $display("FAIL trap_issue: got %h expected 80", if32.i_addr_out);
        end
    endtask

    task automatic test_pending();
        drive32(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (if32.i_addr_out !== 32'h80 || if32.redirect_pending_out !== 1'b0) begin
            errors++; $display("FAIL stall_hold: i_addr=%h flag=%b expected 80/0", if32.i_addr_out, if32.redirect_pending_out);
        end
        drive32(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h80);
        step();
        checks++;
        if (if32.redirect_pending_out !== 1'b1 || if32.i_addr_out !== 32'h80) begin
            errors++; $display("FAIL pending_set: flag=%b i_addr=%h expected 1/80", if32.redirect_pending_out, if32.i_addr_out);
        end
        drive32(1'b0, 2'b01, 1'b0, 32'h0, 32'h44, 32'h80);
        step();
        checks++;
        if (if32.redirect_pending_out !== 1'b1 || if32.i_addr_out !== 32'h80) begin
            errors++; $display("FAIL pending_overwrite: flag=%b i_addr=%h expected 1/80", if32.redirect_pending_out, if32.i_addr_out);
        end
        drive32(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (if32.i_addr_out !== 32'h44 || if32.pc_out !== 32'h44 || if32.redirect_pending_out !== 1'b0) begin
            errors++; $display("FAIL pending_issue: i_addr=%h pc=%h flag=%b expected 44/44/0", if32.i_addr_out, if32.pc_out, if32.redirect_pending_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'h48) begin
            errors++; $display("FAIL resume_seq: got %h expected 48", if32.i_addr_out);
        end
        // Redirect arriving with ready beats the parked one.
        drive32(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h200);
        step();
        drive32(1'b1, 2'b01, 1'b0, 32'h0, 32'h300, 32'h200);
        step();
        checks++;
        if (if32.i_addr_out !== 32'h300 || if32.redirect_pending_out !== 1'b0) begin
            errors++; $display("FAIL incoming_wins: i_addr=%h flag=%b expected 300/0", if32.i_addr_out, if32.redirect_pending_out);
        end
    endtask

    task automatic test_wrap();
        drive32(1'b1, 2'b11, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
        step();
        checks++;
        if (if32.i_addr_out !== 32'hFFFF_FFFC || if32.pc_plus_step_out !== 32'h0) begin
            errors++; $display("FAIL wrap_setup: i_addr=%h step=%h expected fffffffc/0", if32.i_addr_out, if32.pc_plus_step_out);
        end
        drive32(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        checks++;
        if (if32.i_addr_out !== 32'h0) begin
            errors++; $display("FAIL wrap: got %h expected 0", if32.i_addr_out);
        end
    endtask

    task automatic test_async_reset();
        drive32(1'b0, 2'b01, 1'b0, 32'h0, 32'h44, 32'h0);
        step();
        checks++;
        if (if32.redirect_pending_out !== 1'b1) begin
            errors++; $display("FAIL hold_entry: flag=%b expected 1", if32.redirect_pending_out);
        end
        #2 rst32 = 1'b1;
        #1;
        checks++;
        if (if32.i_addr_out !== 32'h0 || if32.pc_out !== 32'h0 || if32.redirect_pending_out !== 1'b0) begin
            errors++; $display("FAIL async_reset: i_addr=%h pc=%h flag=%b expected 0/0/0", if32.i_addr_out, if32.pc_out, if32.redirect_pending_out);
        end
        drive32(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        rst32 = 1'b0;
        step();
        checks++;
        if (if32.i_addr_out !== 32'h0 || if32.redirect_pending_out !== 1'b0) begin
            errors++; $display("FAIL restart_boot: i_addr=%h flag=%b expected 0/0", if32.i_addr_out, if32.redirect_pending_out);
        end
        step();
        checks++;
        if (if32.i_addr_out !== 32'h4) begin
            errors++; $display("FAIL restart_seq: got %h expected 4", if32.i_addr_out);
        end
    endtask

    task automatic test_ialign16();
        rst16 = 1'b0;
        step();
        checks++;
        if (if16.i_addr_out !== 32'h1000) begin
            errors++; $display("FAIL c_boot: got %h expected 1000", if16.i_addr_out);
        end
        if16.branch_taken_in = 1'b1;
        if16.iaddr_in        = 32'h10;
        step();
        if16.branch_taken_in = 1'b0;
        if16.instr_16_in     = 1'b1;
        #1;
        checks++;
        if (if16.i_addr_out !== 32'h10 || if16.pc_plus_step_out !== 32'h12) begin
            errors++; $display("FAIL c_step2: i_addr=%h step=%h expected 10/12", if16.i_addr_out, if16.pc_plus_step_out);
        end
        step();
        checks++;
        if (if16.i_addr_out !== 32'h12) begin
            errors++; $display("FAIL c_seq: got %h expected 12", if16.i_addr_out);
        end
        if16.instr_16_in = 1'b0;
        #1;
        checks++;
        if (if16.pc_plus_step_out !== 32'h16) begin
            errors++; $display("FAIL c_step4: got %h expected 16", if16.pc_plus_step_out);
        end
        if16.branch_taken_in = 1'b1;
        if16.iaddr_in        = 32'h37;
        #1;
        checks++;
        if (if16.misaligned_instr_logic_out !== 1'b0) begin
            errors++; $display("FAIL c_no_misalign: got %b expected 0", if16.misaligned_instr_logic_out);
        end
        step();
        checks++;
        if (if16.i_addr_out !== 32'h36 || if16.pc_out !== 32'h36) begin
            errors++; $display("FAIL c_branch: i_addr=%h pc=%h expected 36", if16.i_addr_out, if16.pc_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst32  = 1'b1;
        rst16  = 1'b1;
        if16.ahb_ready_in    = 1'b1;
        if16.pc_src_in       = 2'b11;
        if16.branch_taken_in = 1'b0;
        if16.iaddr_in        = 32'h0;
        if16.epc_in          = 32'h0;
        if16.trap_address_in = 32'h0;
        if16.instr_16_in     = 1'b0;
        test_reset();
        test_misalign();
        test_pending();
        test_wrap();
        test_async_reset();
        test_ialign16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
